// File: rtl/prim_ram_2p_ctrl.sv
// Two-client controller for a dual-port RAM: clears the RAM through port A after reset,
// then maps client 0 to port A and client 1 to port B with same-address conflict arbitration.
module prim_ram_2p_ctrl #(
    parameter int Width = 32,
    parameter int Depth = 128,
    localparam int Aw   = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             c0_req_i,
    input  logic             c0_write_i,
    input  logic [Aw-1:0]    c0_addr_i,
    input  logic [Width-1:0] c0_wdata_i,
    input  logic [Width-1:0] c0_wmask_i,
    output logic             c0_gnt_o,
    output logic             c0_rvalid_o,
    output logic [Width-1:0] c0_rdata_o,

    input  logic             c1_req_i,
    input  logic             c1_write_i,
    input  logic [Aw-1:0]    c1_addr_i,
    input  logic [Width-1:0] c1_wdata_i,
    input  logic [Width-1:0] c1_wmask_i,
    output logic             c1_gnt_o,
    output logic             c1_rvalid_o,
    output logic [Width-1:0] c1_rdata_o,

    output logic             ram_a_req_o,
    output logic             ram_a_write_o,
    output logic [Aw-1:0]    ram_a_addr_o,
    output logic [Width-1:0] ram_a_wdata_o,
    output logic [Width-1:0] ram_a_wmask_o,
    input  logic [Width-1:0] ram_a_rdata_i,

    output logic             ram_b_req_o,
    output logic             ram_b_write_o,
    output logic [Aw-1:0]    ram_b_addr_o,
    output logic [Width-1:0] ram_b_wdata_o,
    output logic [Width-1:0] ram_b_wmask_o,
    input  logic [Width-1:0] ram_b_rdata_i,

    output logic             init_done_o
);

    localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e          state_q, state_d;
    logic [Aw-1:0]   cnt_q, cnt_d;
    logic            prio_q, prio_d;
    logic            quiet_q, quiet_d;
    logic            rvalid0_q, rvalid0_d;
    logic            rvalid1_q, rvalid1_d;
    logic            conflict;

    assign conflict = c0_req_i & c1_req_i & (c0_addr_i == c1_addr_i)
                    & (c0_write_i | c1_write_i);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        prio_d        = prio_q;
        quiet_d       = 1'b0;
        c0_gnt_o      = 1'b0;
        c1_gnt_o      = 1'b0;
        ram_a_req_o   = 1'b0;
        ram_a_write_o = 1'b0;
        ram_a_addr_o  = '0;
        ram_a_wdata_o = '0;
        ram_a_wmask_o = '0;
        ram_b_req_o   = 1'b0;
        ram_b_write_o = 1'b0;
        ram_b_addr_o  = '0;
        ram_b_wdata_o = '0;
        ram_b_wmask_o = '0;

        unique case (state_q)
            ST_INIT: begin
                // quiet_q keeps every RAM port idle in the cycle right after a reset edge
                if (!quiet_q) begin
                    ram_a_req_o   = 1'b1;
                    ram_a_write_o = 1'b1;
                    ram_a_addr_o  = cnt_q;
                    ram_a_wmask_o = '1;
                    if (cnt_q == LastAddr) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                c0_gnt_o = c0_req_i & ~(conflict & prio_q);
                c1_gnt_o = c1_req_i & ~(conflict & ~prio_q);
                if (conflict) begin
                    prio_d = ~prio_q;
                end
                ram_a_req_o   = c0_gnt_o;
                ram_a_write_o = c0_gnt_o & c0_write_i;
                ram_a_addr_o  = c0_gnt_o ? c0_addr_i  : '0;
                ram_a_wdata_o = c0_gnt_o ? c0_wdata_i : '0;
                ram_a_wmask_o = c0_gnt_o ? c0_wmask_i : '0;
                ram_b_req_o   = c1_gnt_o;
                ram_b_write_o = c1_gnt_o & c1_write_i;
                ram_b_addr_o  = c1_gnt_o ? c1_addr_i  : '0;
                ram_b_wdata_o = c1_gnt_o ? c1_wdata_i : '0;
                ram_b_wmask_o = c1_gnt_o ? c1_wmask_i : '0;
            end
            default: state_d = ST_INIT;
        endcase

        rvalid0_d = c0_gnt_o & ~c0_write_i;
        rvalid1_d = c1_gnt_o & ~c1_write_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            prio_q    <= 1'b0;
            quiet_q   <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prio_q    <= prio_d;
            quiet_q   <= quiet_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign c0_rvalid_o = rvalid0_q;
    assign c1_rvalid_o = rvalid1_q;
    assign c0_rdata_o  = ram_a_rdata_i;
    assign c1_rdata_o  = ram_b_rdata_i;
    assign init_done_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_prim_ram_2p_ctrl.sv
// Scoreboard bench for prim_ram_2p_ctrl: directed scenarios plus random two-client traffic
// checked against a client-level memory/arbitration model.
module tb_prim_ram_2p_ctrl;

    localparam int W  = 32;
    localparam int D  = 128;
    localparam int AW = $clog2(D);

    logic          clk = 1'b0;
    logic          rst_i;
    logic          c0_req_i, c0_write_i, c1_req_i, c1_write_i;
    logic [AW-1:0] c0_addr_i, c1_addr_i;
    logic [W-1:0]  c0_wdata_i, c0_wmask_i, c1_wdata_i, c1_wmask_i;
    logic          c0_gnt_o, c0_rvalid_o, c1_gnt_o, c1_rvalid_o;
    logic [W-1:0]  c0_rdata_o, c1_rdata_o;
    logic          ram_a_req_o, ram_a_write_o, ram_b_req_o, ram_b_write_o;
    logic [AW-1:0] ram_a_addr_o, ram_b_addr_o;
    logic [W-1:0]  ram_a_wdata_o, ram_a_wmask_o, ram_b_wdata_o, ram_b_wmask_o;
    logic [W-1:0]  ram_a_rdata_i, ram_b_rdata_i;
    logic          init_done_o;

    always #5 clk = ~clk;

    prim_ram_2p_ctrl #(.Width(W), .Depth(D)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .c0_req_i(c0_req_i), .c0_write_i(c0_write_i), .c0_addr_i(c0_addr_i),
        .c0_wdata_i(c0_wdata_i), .c0_wmask_i(c0_wmask_i), .c0_gnt_o(c0_gnt_o),
        .c0_rvalid_o(c0_rvalid_o), .c0_rdata_o(c0_rdata_o),
        .c1_req_i(c1_req_i), .c1_write_i(c1_write_i), .c1_addr_i(c1_addr_i),
        .c1_wdata_i(c1_wdata_i), .c1_wmask_i(c1_wmask_i), .c1_gnt_o(c1_gnt_o),
        .c1_rvalid_o(c1_rvalid_o), .c1_rdata_o(c1_rdata_o),
        .ram_a_req_o(ram_a_req_o), .ram_a_write_o(ram_a_write_o), .ram_a_addr_o(ram_a_addr_o),
        .ram_a_wdata_o(ram_a_wdata_o), .ram_a_wmask_o(ram_a_wmask_o), .ram_a_rdata_i(ram_a_rdata_i),
        .ram_b_req_o(ram_b_req_o), .ram_b_write_o(ram_b_write_o), .ram_b_addr_o(ram_b_addr_o),
        .ram_b_wdata_o(ram_b_wdata_o), .ram_b_wmask_o(ram_b_wmask_o), .ram_b_rdata_i(ram_b_rdata_i),
        .init_done_o(init_done_o)
    );

    // Attached RAM: starts full of garbage so an incomplete clear shows up on later reads.
    logic [W-1:0] ram [D];
    logic         ram_filled = 1'b0;
    always @(posedge clk) begin
        if (!ram_filled) begin
            for (int i = 0; i < D; i++) ram[i] <= $urandom;
            ram_filled <= 1'b1;
        end else begin
            if (ram_a_req_o && !ram_a_write_o) ram_a_rdata_i <= ram[ram_a_addr_o];
            if (ram_b_req_o && !ram_b_write_o) ram_b_rdata_i <= ram[ram_b_addr_o];
            if (ram_a_req_o && ram_a_write_o)
                ram[ram_a_addr_o] <= (ram[ram_a_addr_o] & ~ram_a_wmask_o) | (ram_a_wdata_o & ram_a_wmask_o);
            if (ram_b_req_o && ram_b_write_o)
                ram[ram_b_addr_o] <= (ram[ram_b_addr_o] & ~ram_b_wmask_o) | (ram_b_wdata_o & ram_b_wmask_o);
        end
    end

    typedef struct {
        int unsigned  due;
        logic [W-1:0] data;
    } rd_t;

    rd_t          q0[$];
    rd_t          q1[$];
    int unsigned  cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic         mprio;
    logic [W-1:0] mmem [D];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle each client's rvalid must match whether a read response is due now.
    always @(negedge clk) begin
        if (q0.size() > 0 && q0[0].due == cyc) begin
            chk1("c0_rvalid", c0_rvalid_o, 1'b1);
            chkw("c0_rdata", c0_rdata_o, q0[0].data);
            void'(q0.pop_front());
        end else begin
            chk1("c0_rvalid_idle", c0_rvalid_o, 1'b0);
        end
        if (q1.size() > 0 && q1[0].due == cyc) begin
            chk1("c1_rvalid", c1_rvalid_o, 1'b1);
            chkw("c1_rdata", c1_rdata_o, q1[0].data);
            void'(q1.pop_front());
        end else begin
            chk1("c1_rvalid_idle", c1_rvalid_o, 1'b0);
        end
    end

    // Called at a negedge; the following posedge samples reset.
    task automatic do_reset();
        rst_i    = 1'b1;
        c0_req_i = 1'b0;
        c1_req_i = 1'b0;
        q0.delete();
        q1.delete();
        mprio = 1'b0;
        @(negedge clk);
        chk1("rst_ram_a_req", ram_a_req_o, 1'b0);
        chk1("rst_ram_b_req", ram_b_req_o, 1'b0);
        chk1("rst_c0_rvalid", c0_rvalid_o, 1'b0);
        chk1("rst_c1_rvalid", c1_rvalid_o, 1'b0);
        chk1("rst_init_done", init_done_o, 1'b0);
        rst_i = 1'b0;
    endtask

    task automatic init_run(input int n, input bit expect_done);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk1("init_a_req", ram_a_req_o, 1'b1);
            chk1("init_a_write", ram_a_write_o, 1'b1);
            chka("init_a_addr", ram_a_addr_o, AW'(i));
            chkw("init_a_wdata", ram_a_wdata_o, '0);
            chkw("init_a_wmask", ram_a_wmask_o, '1);
            chk1("init_b_req", ram_b_req_o, 1'b0);
            chk1("init_c0_gnt", c0_gnt_o, 1'b0);
            chk1("init_c1_gnt", c1_gnt_o, 1'b0);
            chk1("init_done_low", init_done_o, 1'b0);
            c0_req_i   = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            c1_req_i   = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            c0_write_i = 1'($urandom_range(0, 1));
            c1_write_i = 1'($urandom_range(0, 1));
            c0_addr_i  = AW'($urandom_range(0, 3));
            c1_addr_i  = AW'($urandom_range(0, 3));
        end
        if (expect_done) begin
            @(negedge clk);
            chk1("init_done_high", init_done_o, 1'b1);
            for (int i = 0; i < D; i++) mmem[i] = '0;
        end
    endtask

    // One client cycle: drive, then compare grants/RAM ports against the model and queue reads.
    task automatic step(input logic r0, input logic w0, input logic [AW-1:0] a0,
                        input logic [W-1:0] d0, input logic [W-1:0] m0,
                        input logic r1, input logic w1, input logic [AW-1:0] a1,
                        input logic [W-1:0] d1, input logic [W-1:0] m1,
                        output logic ag0, output logic ag1);
        logic conf, eg0, eg1;
        rd_t  e;
        @(posedge clk);
        #1;
        c0_req_i = r0; c0_write_i = w0; c0_addr_i = a0; c0_wdata_i = d0; c0_wmask_i = m0;
        c1_req_i = r1; c1_write_i = w1; c1_addr_i = a1; c1_wdata_i = d1; c1_wmask_i = m1;
        @(negedge clk);
        conf = r0 && r1 && (a0 == a1) && (w0 || w1);
        eg0  = r0 && !(conf && mprio);
        eg1  = r1 && !(conf && !mprio);
        chk1("c0_gnt", c0_gnt_o, eg0);
        chk1("c1_gnt", c1_gnt_o, eg1);
        chk1("ram_a_req", ram_a_req_o, eg0);
        chk1("ram_b_req", ram_b_req_o, eg1);
        if (eg0) begin
            chk1("ram_a_write", ram_a_write_o, w0);
            chka("ram_a_addr", ram_a_addr_o, a0);
            if (w0) begin
                chkw("ram_a_wdata", ram_a_wdata_o, d0);
                chkw("ram_a_wmask", ram_a_wmask_o, m0);
            end
        end
        if (eg1) begin
            chk1("ram_b_write", ram_b_write_o, w1);
            chka("ram_b_addr", ram_b_addr_o, a1);
            if (w1) begin
                chkw("ram_b_wdata", ram_b_wdata_o, d1);
                chkw("ram_b_wmask", ram_b_wmask_o, m1);
            end
        end
        ag0 = c0_gnt_o;
        ag1 = c1_gnt_o;
        if (eg0 && !w0) begin e.due = cyc + 1; e.data = mmem[a0]; q0.push_back(e); end
        if (eg1 && !w1) begin e.due = cyc + 1; e.data = mmem[a1]; q1.push_back(e); end
        if (eg0 && w0) mmem[a0] = (mmem[a0] & ~m0) | (d0 & m0);
        if (eg1 && w1) mmem[a1] = (mmem[a1] & ~m1) | (d1 & m1);
        if (conf) mprio = eg0;
    endtask

    task automatic idle();
        logic g0, g1;
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, g0, g1);
    endtask

    logic          g0, g1, r0, w0, r1, w1, pend0, pend1;
    logic [AW-1:0] a0, a1;
    logic [W-1:0]  d0, m0, d1, m1;

    initial begin
        rst_i = 1'b1;
        c0_req_i = 1'b0; c0_write_i = 1'b0; c0_addr_i = '0; c0_wdata_i = '0; c0_wmask_i = '0;
        c1_req_i = 1'b0; c1_write_i = 1'b0; c1_addr_i = '0; c1_wdata_i = '0; c1_wmask_i = '0;
        mprio = 1'b0;

        do_reset();
        init_run(D, 1'b1);

        // Reset partway through the clear restarts it from address 0.
        do_reset();
        init_run(51, 1'b0);
        do_reset();
        init_run(D, 1'b1);

        // Write then read on the other client.
        step(1'b1, 1'b1, AW'(5), 32'hDEADBEEF, '1, 1'b0, 1'b0, '0, '0, '0, g0, g1);
        chk1("wr_c0_gnt", g0, 1'b1);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, AW'(5), '0, '0, g0, g1);
        chk1("rd_c1_gnt", g1, 1'b1);
        idle();
        chk1("rd_c1_rvalid", c1_rvalid_o, 1'b1);
        chkw("rd_c1_rdata", c1_rdata_o, 32'hDEADBEEF);

        // Write-write conflict on one address alternates winners.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, AW'(9), $urandom, '1, 1'b1, 1'b1, AW'(9), $urandom, '1, g0, g1);
            chk1("alt_c0_gnt", g0, 1'(k % 2 == 0));
            chk1("alt_c1_gnt", g1, 1'(k % 2 == 1));
            chk1("alt_one_port", ram_a_req_o ^ ram_b_req_o, 1'b1);
        end

        // Read-read on one address: both granted, priority left alone.
        step(1'b1, 1'b0, AW'(3), '0, '0, 1'b1, 1'b0, AW'(3), '0, '0, g0, g1);
        chk1("rr_c0_gnt", g0, 1'b1);
        chk1("rr_c1_gnt", g1, 1'b1);
        idle();
        chk1("rr_c0_rvalid", c0_rvalid_o, 1'b1);
        chk1("rr_c1_rvalid", c1_rvalid_o, 1'b1);
        step(1'b1, 1'b1, AW'(3), 32'h1234_5678, '1, 1'b1, 1'b1, AW'(3), 32'h8765_4321, '1, g0, g1);
        chk1("rr_prio_c0_wins", g0, 1'b1);
        chk1("rr_prio_c1_loses", g1, 1'b0);

        // Reset right after a granted read drops the pending response.
        step(1'b1, 1'b0, AW'(7), '0, '0, 1'b0, 1'b0, '0, '0, '0, g0, g1);
        chk1("rst_rd_c0_gnt", g0, 1'b1);
        do_reset();
        init_run(D, 1'b1);

        // Random traffic; a denied client holds its request until granted.
        pend0 = 1'b0;
        pend1 = 1'b0;
        for (int it = 0; it < 1500; it++) begin
            if (!pend0) begin
                r0 = ($urandom_range(0, 9) < 7);
                w0 = 1'($urandom_range(0, 1));
                a0 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, D - 1)) : AW'($urandom_range(0, 7));
                d0 = $urandom;
                m0 = ($urandom_range(0, 1) == 1) ? '1 : $urandom;
            end
            if (!pend1) begin
                r1 = ($urandom_range(0, 9) < 7);
                w1 = 1'($urandom_range(0, 1));
                a1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, D - 1)) : AW'($urandom_range(0, 7));
                d1 = $urandom;
                m1 = ($urandom_range(0, 1) == 1) ? '1 : $urandom;
            end
            step(r0, w0, a0, d0, m0, r1, w1, a1, d1, m1, g0, g1);
            pend0 = r0 && !g0;
            pend1 = r1 && !g1;
        end
        idle();
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
